// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 5-stage RV32I core pipeline registers.
//   - Bit positions inside the decoded control bundle (ctrl[CTRL_W-1:0]).
//   - Default control-bundle width.
//   - Bubble (NOP) control value and the x0 register index.
//   - wb_bypass_hit(): decides whether the write-back result must replace a
//     register-file read captured in the same cycle.
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int CTRL_W_DEFAULT  = 8;

  // Control bundle bit positions
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_ALU_OP_LO  = 6;
  localparam int CTRL_ALU_OP_HI  = 7;

  // A bubble carries no side effects: every control bit is clear.
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;

  localparam logic [4:0] REG_X0 = 5'd0;

  // WB writes the register file in the same cycle ID reads it, so the read
  // data is stale; x0 is never bypassed because it is hard-wired to zero.
  function automatic logic wb_bypass_hit(input logic       we,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] rs);
    return we && (wb_rd != REG_X0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detection and pipeline stall generation.
// Ports:
//   i_id_ex_valid     instruction currently held in ID/EX is real
//   i_id_ex_mem_read  that instruction is a load
//   i_id_ex_rd        its destination register
//   i_id_valid        ID holds a real instruction
//   i_id_rs1/rs2      ID source registers
//   i_ex_flush        taken branch/jump in EX
//   i_hold            downstream freeze
//   o_lu              load-use hazard between ID/EX and ID
//   o_stall           freeze PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module hazard_detect (
  input  logic       i_id_ex_valid,
  input  logic       i_id_ex_mem_read,
  input  logic [4:0] i_id_ex_rd,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_ex_flush,
  input  logic       i_hold,
  output logic       o_lu,
  output logic       o_stall
);
  import core_pkg::*;

  logic w_rd_match;

  // Both sources are compared regardless of whether the instruction reads
  // rs2; an occasional spurious bubble is cheaper than decoding usage here.
  assign w_rd_match = (i_id_ex_rd == i_id_rs1) || (i_id_ex_rd == i_id_rs2);

  assign o_lu = i_id_ex_valid && i_id_ex_mem_read && (i_id_ex_rd != REG_X0) &&
                i_id_valid && w_rd_match;

  // A flush kills the ID instruction, so there is nothing left to stall for.
  assign o_stall = !i_ex_flush && (o_lu || i_hold);

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the RV32I core.
// Captures decoded operands/control from ID (with WB->ID bypass applied),
// inserts a bubble on load-use hazards or branch flush, freezes on hold and
// counts stall / flush events in saturating counters.
// Ports:
//   clk, rst                      clock, async active-high reset
//   id_*                          ID-stage instruction fields
//   mem_wb_reg_write/rd/data      write-back port (for bypass)
//   ex_flush                      kill ID instruction (bubble)
//   hold                          freeze the stage
//   id_ex_*                       registered bundle presented to EX
//   stall                         combinational freeze of PC and IF/ID
//   stall_count, flush_count      saturating event counters
// Update priority per edge: ex_flush > hold > load-use > capture.
// -----------------------------------------------------------------------------
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              mem_wb_reg_write,
  input  logic [4:0]        mem_wb_rd,
  input  logic [XLEN-1:0]   mem_wb_data,
  input  logic              ex_flush,
  input  logic              hold,
  output logic              id_ex_valid,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [4:0]        id_ex_rs1,
  output logic [4:0]        id_ex_rs2,
  output logic [4:0]        id_ex_rd,
  output logic [XLEN-1:0]   id_ex_rs1_data,
  output logic [XLEN-1:0]   id_ex_rs2_data,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_flush_count;

  logic              w_lu;
  logic              w_stall;
  logic              w_bubble;
  logic              w_stall_evt;
  logic [XLEN-1:0]   w_rs1_fwd;
  logic [XLEN-1:0]   w_rs2_fwd;

  hazard_detect u_hazard_detect (
    .i_id_ex_valid    (r_valid),
    .i_id_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
    .i_id_ex_rd       (r_rd),
    .i_id_valid       (id_valid),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_ex_flush       (ex_flush),
    .i_hold           (hold),
    .o_lu             (w_lu),
    .o_stall          (w_stall)
  );

  assign w_rs1_fwd = wb_bypass_hit(mem_wb_reg_write, mem_wb_rd, id_rs1) ? mem_wb_data
                                                                        : id_rs1_data;
  assign w_rs2_fwd = wb_bypass_hit(mem_wb_reg_write, mem_wb_rd, id_rs2) ? mem_wb_data
                                                                        : id_rs2_data;

  // Flush always wins; a load-use bubble waits until hold releases so the
  // load stays in ID/EX (and lu stays asserted) for the whole freeze.
  assign w_bubble    = ex_flush || (!hold && w_lu);
  assign w_stall_evt = !ex_flush && !hold && w_lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= REG_X0;
      r_rs2      <= REG_X0;
      r_rd       <= REG_X0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_ctrl     <= CTRL_W'(CTRL_BUBBLE);
    end else if (w_bubble) begin
      // Zero register indices guarantee EX forwarding never matches a bubble.
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= REG_X0;
      r_rs2      <= REG_X0;
      r_rd       <= REG_X0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_ctrl     <= CTRL_W'(CTRL_BUBBLE);
    end else if (!hold) begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_rs1_data <= w_rs1_fwd;
      r_rs2_data <= w_rs2_fwd;
      r_imm      <= id_imm;
      r_ctrl     <= id_ctrl;
    end
  end

  // Saturating event counters: stick at all-ones, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (ex_flush && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
      if (w_stall_evt && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign id_ex_valid    = r_valid;
  assign id_ex_pc       = r_pc;
  assign id_ex_rs1      = r_rs1;
  assign id_ex_rs2      = r_rs2;
  assign id_ex_rd       = r_rd;
  assign id_ex_rs1_data = r_rs1_data;
  assign id_ex_rs2_data = r_rs2_data;
  assign id_ex_imm      = r_imm;
  assign id_ex_ctrl     = r_ctrl;
  assign stall          = w_stall;
  assign stall_count    = r_stall_count;
  assign flush_count    = r_flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: explicit vector table, hand-written
// multi-cycle sequences (load-use, flush vs load-use, hold, saturation,
// asynchronous reset) and randomized traffic checked against a reference
// model of the stage's rules.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [7:0] LOAD_CTRL = 8'h1B; // reg_write|mem_read|mem_to_reg|alu_src
  localparam logic [7:0] ADD_CTRL  = 8'h81; // reg_write, alu_op=2

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              mem_wb_reg_write;
  logic [4:0]        mem_wb_rd;
  logic [XLEN-1:0]   mem_wb_data;
  logic              ex_flush, hold;
  logic              id_ex_valid;
  logic [XLEN-1:0]   id_ex_pc;
  logic [4:0]        id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [XLEN-1:0]   id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              stall;
  logic [CNT_W-1:0]  stall_count, flush_count;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rd            (id_rd),
    .id_rs1_data      (id_rs1_data),
    .id_rs2_data      (id_rs2_data),
    .id_imm           (id_imm),
    .id_ctrl          (id_ctrl),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_data      (mem_wb_data),
    .ex_flush         (ex_flush),
    .hold             (hold),
    .id_ex_valid      (id_ex_valid),
    .id_ex_pc         (id_ex_pc),
    .id_ex_rs1        (id_ex_rs1),
    .id_ex_rs2        (id_ex_rs2),
    .id_ex_rd         (id_ex_rd),
    .id_ex_rs1_data   (id_ex_rs1_data),
    .id_ex_rs2_data   (id_ex_rs2_data),
    .id_ex_imm        (id_ex_imm),
    .id_ex_ctrl       (id_ex_ctrl),
    .stall            (stall),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Holds what EX should see; events counted as plain integers and clipped
  // to the counter range only when compared.
  logic              m_valid;
  logic [XLEN-1:0]   m_pc, m_d1, m_d2, m_imm;
  logic [4:0]        m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_stalls, m_flushes;

  function automatic int sat(input int c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0;
  endtask

  task automatic model_reset();
    model_bubble();
    m_stalls = 0;
    m_flushes = 0;
  endtask

  // A load in EX whose result a real ID instruction reads (either source).
  function automatic logic model_lu();
    return m_valid && m_ctrl[1] && (m_rd != 5'd0) && id_valid &&
           ((m_rd == id_rs1) || (m_rd == id_rs2));
  endfunction

  function automatic logic model_stall();
    return !ex_flush && (model_lu() || hold);
  endfunction

  function automatic logic [XLEN-1:0] model_read(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == rs) return mem_wb_data;
    return rf;
  endfunction

  task automatic model_edge();
    if (ex_flush) begin
      model_bubble();
      m_flushes++;
    end else if (hold) begin
      // frozen
    end else if (model_lu()) begin
      model_bubble();
      m_stalls++;
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = model_read(id_rs1, id_rs1_data);
      m_d2 = model_read(id_rs2, id_rs2_data);
      m_imm = id_imm; m_ctrl = id_ctrl;
    end
  endtask

  task automatic check_all();
    chk("valid",    32'(id_ex_valid),    32'(m_valid));
    chk("pc",       id_ex_pc,            m_pc);
    chk("rs1",      32'(id_ex_rs1),      32'(m_rs1));
    chk("rs2",      32'(id_ex_rs2),      32'(m_rs2));
    chk("rd",       32'(id_ex_rd),       32'(m_rd));
    chk("rs1_data", id_ex_rs1_data,      m_d1);
    chk("rs2_data", id_ex_rs2_data,      m_d2);
    chk("imm",      id_ex_imm,           m_imm);
    chk("ctrl",     32'(id_ex_ctrl),     32'(m_ctrl));
    chk("stall_count", 32'(stall_count), 32'(sat(m_stalls)));
    chk("flush_count", 32'(flush_count), 32'(sat(m_flushes)));
  endtask

  // Inputs are driven just after a falling edge; stall is checked before the
  // rising edge, registered outputs just after it.
  task automatic cycle();
    #1;
    chk("stall", 32'(stall), 32'(model_stall()));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [7:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    mem_wb_reg_write = we; mem_wb_rd = rd; mem_wb_data = data;
  endtask

  task automatic drive_random();
    drive_id($urandom_range(0, 99) < 85, $urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, 8'($urandom));
    drive_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    ex_flush = $urandom_range(0, 99) < 10;
    hold     = $urandom_range(0, 99) < 15;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2;
    logic [7:0]  ctrl;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        flush;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_d1, e_d2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    rst = 1'b1;
    drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    drive_wb(1'b0, '0, '0);
    ex_flush = 1'b0;
    hold = 1'b0;
    model_reset();

    // Plain capture / bypass / flush vectors; no loads, so no load-use.
    vecs[0] = '{1'b1, 32'h10, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, ADD_CTRL,
                1'b0, 5'd0, 32'h0, 1'b0,   1'b1, 5'd3, 32'h11, 32'h22};
    vecs[1] = '{1'b1, 32'h14, 5'd1, 5'd7, 5'd4, 32'h33, 32'h0, ADD_CTRL,
                1'b1, 5'd7, 32'hDEADBEEF, 1'b0,   1'b1, 5'd4, 32'h33, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h18, 5'd0, 5'd0, 5'd5, 32'h1111, 32'h5A5A, ADD_CTRL,
                1'b1, 5'd0, 32'hDEADBEEF, 1'b0,   1'b1, 5'd5, 32'h1111, 32'h5A5A};
    vecs[3] = '{1'b1, 32'h1C, 5'd7, 5'd2, 5'd6, 32'h44, 32'h55, ADD_CTRL,
                1'b0, 5'd7, 32'hCAFEF00D, 1'b0,   1'b1, 5'd6, 32'h44, 32'h55};
    vecs[4] = '{1'b1, 32'h20, 5'd9, 5'd9, 5'd10, 32'h66, 32'h77, ADD_CTRL,
                1'b1, 5'd9, 32'h12345678, 1'b0,   1'b1, 5'd10, 32'h12345678, 32'h12345678};
    vecs[5] = '{1'b1, 32'h24, 5'd1, 5'd2, 5'd11, 32'h88, 32'h99, ADD_CTRL,
                1'b0, 5'd0, 32'h0, 1'b1,   1'b0, 5'd0, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 32'h28, 5'd3, 5'd4, 5'd12, 32'hAA, 32'hBB, 8'h00,
                1'b0, 5'd0, 32'h0, 1'b0,   1'b0, 5'd12, 32'hAA, 32'hBB};

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(id_ex_valid), 32'h0);
    chk("rst_rd",    32'(id_ex_rd),    32'h0);
    chk("rst_ctrl",  32'(id_ex_ctrl),  32'h0);
    chk("rst_stall", 32'(stall),       32'h0);
    chk("rst_scnt",  32'(stall_count), 32'h0);
    chk("rst_fcnt",  32'(flush_count), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table ----
    for (int i = 0; i < 7; i++) begin
      drive_id(vecs[i].v, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
               vecs[i].d1, vecs[i].d2, 32'h100 + 32'(i), vecs[i].ctrl);
      drive_wb(vecs[i].we, vecs[i].wrd, vecs[i].wdata);
      ex_flush = vecs[i].flush;
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(id_ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_rd", i),    32'(id_ex_rd),    32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_d1", i),    id_ex_rs1_data,   vecs[i].e_d1);
      chk($sformatf("vec%0d_d2", i),    id_ex_rs2_data,   vecs[i].e_d2);
    end
    ex_flush = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);

    // ---- load x5, then add x6, x5, x1 ----
    drive_id(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h8, LOAD_CTRL);
    cycle();
    drive_id(1'b1, 32'h104, 5'd5, 5'd1, 5'd6, 32'h50, 32'h10, 32'h0, ADD_CTRL);
    #1;
    chk("lu_stall_hi", 32'(stall), 32'h1);
    cycle();
    chk("lu_bubble_rd",    32'(id_ex_rd),    32'h0);
    chk("lu_bubble_valid", 32'(id_ex_valid), 32'h0);
    chk("lu_scnt_1",       32'(stall_count), 32'h1);
    #1;
    chk("lu_stall_lo", 32'(stall), 32'h0);
    cycle();
    chk("lu_rs1_5",   32'(id_ex_rs1),   32'h5);
    chk("lu_rd_6",    32'(id_ex_rd),    32'h6);
    chk("lu_scnt_1b", 32'(stall_count), 32'h1);

    // ---- ex_flush and load-use together: flush wins ----
    drive_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, LOAD_CTRL);
    cycle();
    drive_id(1'b1, 32'h204, 5'd8, 5'd3, 5'd9, 32'h1, 32'h2, 32'h0, ADD_CTRL);
    ex_flush = 1'b1;
    #1;
    chk("fl_lu_stall", 32'(stall), 32'h0);
    cycle();
    ex_flush = 1'b0;
    chk("fl_lu_valid", 32'(id_ex_valid), 32'h0);
    chk("fl_lu_rd",    32'(id_ex_rd),    32'h0);
    chk("fl_lu_fcnt",  32'(flush_count), 32'h2);
    chk("fl_lu_scnt",  32'(stall_count), 32'h1);

    // ---- hold for 3 cycles with a valid instruction in ID/EX ----
    drive_id(1'b1, 32'h300, 5'd3, 5'd4, 5'd9, 32'h31, 32'h41, 32'h7, ADD_CTRL);
    cycle();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_id(1'b1, 32'h400 + 32'(4 * k), 5'd10, 5'd11, 5'd12, 32'h0, 32'h0, 32'h0, ADD_CTRL);
      #1;
      chk($sformatf("hold%0d_stall", k), 32'(stall), 32'h1);
      cycle();
      chk($sformatf("hold%0d_pc", k), id_ex_pc, 32'h300);
      chk($sformatf("hold%0d_rd", k), 32'(id_ex_rd), 32'h9);
    end
    hold = 1'b0;
    drive_id(1'b1, 32'h500, 5'd13, 5'd14, 5'd15, 32'h0, 32'h0, 32'h0, ADD_CTRL);
    cycle();
    chk("hold_resume_pc", id_ex_pc, 32'h500);

    // ---- hold during load-use: register frozen, bubble after release ----
    drive_id(1'b1, 32'h600, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, LOAD_CTRL);
    cycle();
    drive_id(1'b1, 32'h604, 5'd3, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, ADD_CTRL);
    hold = 1'b1;
    repeat (2) begin
      cycle();
      chk("hold_lu_rd", 32'(id_ex_rd), 32'h7);
    end
    hold = 1'b0;
    #1;
    chk("hold_lu_stall", 32'(stall), 32'h1);
    cycle();
    chk("hold_lu_bubble", 32'(id_ex_rd),    32'h0);
    chk("hold_lu_scnt",   32'(stall_count), 32'h2);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      drive_random();
      cycle();
    end
    ex_flush = 1'b0;
    hold = 1'b0;

    // ---- saturation: 2^CNT_W+2 flushes after a fresh reset ----
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    ex_flush = 1'b1;
    for (int n = 0; n < CNT_MAX + 3; n++) begin
      drive_random();
      ex_flush = 1'b1;
      cycle();
      chk("fcnt_nonzero", 32'(flush_count == '0), 32'h0);
    end
    chk("fcnt_sat", 32'(flush_count), 32'(CNT_MAX));
    ex_flush = 1'b0;
    hold = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);

    // ---- asynchronous reset in the middle of a load-use stall ----
    drive_id(1'b1, 32'h700, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, LOAD_CTRL);
    cycle();
    drive_id(1'b1, 32'h704, 5'd5, 5'd6, 5'd6, 32'h0, 32'h0, 32'h0, ADD_CTRL);
    #1;
    chk("arst_pre_stall", 32'(stall), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(id_ex_valid), 32'h0);
    chk("arst_stall", 32'(stall),       32'h0);
    chk("arst_scnt",  32'(stall_count), 32'h0);
    chk("arst_fcnt",  32'(flush_count), 32'h0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    cycle();
    chk("post_rst_capture_pc", id_ex_pc, 32'h704);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage RV32I core. It registers decoded operands and control from ID and presents them to EX as the `id_ex_*` bundle; the EX-side forwarding unit consumes `id_ex_rs1`/`id_ex_rs2` from that bundle. The stage also:
- detects load-use hazards and inserts bubbles;
- applies the write-back-to-decode bypass;
- honours branch flush and global hold;
- keeps saturating stall and flush event counters.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.
- `CTRL_W`, default 8: control bundle width. Bit positions are defined in the package.
- `CNT_W`, default 16: event counter width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  XLEN  PC of the ID instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_rs1_data`, `id_rs2_data`  in  XLEN each  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_ctrl`  in  CTRL_W  decoded control.
- `mem_wb_reg_write`  in  1  WB writes the register file this cycle.
- `mem_wb_rd`  in  5  WB destination register.
- `mem_wb_data`  in  XLEN  WB data.
- `ex_flush`  in  1  branch/jump taken in EX; kill the instruction in ID.
- `hold`  in  1  downstream freeze (memory wait).
- `id_ex_valid`, `id_ex_pc`, `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd`, `id_ex_rs1_data`, `id_ex_rs2_data`, `id_ex_imm`, `id_ex_ctrl`  out  registered copies of the ID fields.
- `stall`  out  1  combinational; freezes PC and IF/ID.
- `stall_count`, `flush_count`  out  CNT_W each  event counters.

## Operation
- Bubble value:
  - `id_ex_valid`, `id_ex_ctrl`, `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd` = 0.
  - The data, immediate and PC fields = 0.
  - Because the register indices are zero, downstream forwarding never matches a bubble.
- Load-use hazard condition, `lu`. All of the following must hold:
  - `id_ex_valid`;
  - `id_ex_ctrl[CTRL_MEM_READ]`;
  - `id_ex_rd` ≠ 0;
  - `id_valid`;
  - `id_ex_rd` == `id_rs1` or `id_ex_rd` == `id_rs2`.
  - Both sources are always compared, even for instructions that use only one (conservative).
- WB bypass at capture: `id_rsN_data` is replaced by `mem_wb_data` when `mem_wb_reg_write`, `mem_wb_rd` ≠ 0 and `mem_wb_rd` == `id_rsN`.
- Register update priority on each `clk` edge:
  1. `ex_flush`: load a bubble; `flush_count` +1.
  2. `hold`: keep all `id_ex_*` unchanged; no count.
  3. `lu`: load a bubble; `stall_count` +1.
  4. Otherwise: capture the ID fields (with bypass applied); `id_ex_valid` = `id_valid`.
- `stall` = !`ex_flush` && (`lu` || `hold`).
- Counters saturate at all-ones and never wrap. They are not cleared except by `rst`.

## Timing
- Latency: one cycle from ID inputs to `id_ex_*`.
- `stall` is combinational from the current `id_ex_*` register state and the ID, `hold` and `ex_flush` inputs. It has no registered delay.
- A load-use case costs exactly one bubble. On the next cycle the load has moved on and `lu` drops, unless `hold` keeps it in place.
- Simultaneous `ex_flush` and `lu`: the flush wins. `stall` = 0 and only `flush_count` increments.
- Simultaneous `hold` and `lu`: the register holds and `stall` = 1. The bubble is inserted only on the first non-hold cycle.
- Reset:
  - Asynchronous: all `id_ex_*` take the bubble value and both counters go to 0 immediately.
  - Outputs are valid in the first cycle after `rst` deasserts.
  - Reset mid-stall drops `stall` once the registers have cleared.

## Structure
- Shared package `core_pkg` holds:
  - control bit positions: `CTRL_REG_WRITE` = 0, `CTRL_MEM_READ` = 1, `CTRL_MEM_WRITE` = 2, `CTRL_MEM_TO_REG` = 3, `CTRL_ALU_SRC` = 4, `CTRL_BRANCH` = 5, `CTRL_ALU_OP` = [7:6];
  - the `CTRL_W` default;
  - the bubble constant.
- One sub-module, `hazard_detect`: combinational `lu` and `stall` generation.
- The register bank, WB bypass muxes and counters stay in the top module.

## Test plan
- Load x5, then `add x6, x5, x1` enters ID.
  - Required: `stall` = 1 for one cycle and a bubble in ID/EX (`id_ex_rd` = 0).
  - Next cycle: `id_ex_rs1` = 5, `stall` = 0, `stall_count` = 1.
- `mem_wb_rd` = 7, `mem_wb_data` = 0xDEADBEEF, `mem_wb_reg_write` = 1, `id_rs2` = 7, `id_rs2_data` = 0x0.
  - Required: `id_ex_rs2_data` = 0xDEADBEEF next cycle.
- Same bypass with `mem_wb_rd` = 0.
  - Required: `id_ex_rs1_data`/`id_ex_rs2_data` take the register-file value unchanged.
- `ex_flush` and `lu` in the same cycle.
  - Required: `stall` = 0, bubble loaded, `flush_count` +1, `stall_count` unchanged.
- `hold` for 3 cycles with a valid instruction in ID/EX.
  - Required: `id_ex_*` constant and `stall` = 1 for all 3 cycles; capture resumes on the 4th edge.
- Counter saturation and reset.
  - Force 2^CNT_W+2 flushes: `flush_count` = all-ones, never 0.
  - Pulse `rst` between clock edges: counters and `id_ex_valid` = 0 immediately.
